mem_access_unit: RTL and testbench

- Memory-stage consumer of the execute-stage result bundle (ALU result, store data, branch target, zero flag) in the 64-bit LEGv8 pipeline.
- Resolves conditional branches and performs loads/stores to data memory through a req/gnt/rvalid handshake.
- Stalls the execute stage while an access is outstanding.
- Hands one result per instruction to write-back.

---
 rtl/mem_access_pkg.sv | 16 +
 rtl/mem_access_unit.sv | 183 ++++++++++++++++++
 tb/tb_mem_access_unit.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/mem_access_pkg.sv
// Shared types and helpers for the LEGv8 memory-stage access unit.
package mem_access_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } mau_state_t;

  // Number of low address bits that must be zero for a word-aligned access.
  function automatic int align_bits(input int n);
    return $clog2(n / 8);
  endfunction

endpackage

// File: rtl/mem_access_unit.sv
// Memory-stage unit: resolves CBZ, runs one load/store at a time over a
// req/gnt/rvalid handshake, and emits one write-back result per instruction.
module mem_access_unit
  import mem_access_pkg::*;
#(
  parameter int N = 64
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         valid_E,
  input  logic         memRead_E,
  input  logic         memWrite_E,
  input  logic         branch_E,
  input  logic [N-1:0] aluResult_E,
  input  logic [N-1:0] writeData_E,
  input  logic [N-1:0] PCBranch_E,
  input  logic         zero_E,
  output logic         ready_E,
  output logic         dm_req,
  output logic         dm_we,
  output logic [N-1:0] dm_addr,
  output logic [N-1:0] dm_wdata,
  input  logic         dm_gnt,
  input  logic         dm_rvalid,
  input  logic [N-1:0] dm_rdata,
  output logic         valid_W,
  output logic [N-1:0] aluResult_W,
  output logic [N-1:0] readData_W,
  output logic         misalign_W,
  output logic         PCSrc_M,
  output logic [N-1:0] PCBranch_M
);

  localparam int ALIGN_BITS = align_bits(N);

  mau_state_t   state_q, state_d;
  logic [N-1:0] alu_q, alu_d;
  logic [N-1:0] wdata_q, wdata_d;
  logic         is_load_q, is_load_d;
  logic         is_store_q, is_store_d;
  logic         ready_q, ready_d;
  logic         dm_req_q, dm_req_d;
  logic         dm_we_q, dm_we_d;
  logic         valid_w_q, valid_w_d;
  logic [N-1:0] alu_w_q, alu_w_d;
  logic [N-1:0] rdata_w_q, rdata_w_d;
  logic         misalign_w_q, misalign_w_d;
  logic         pcsrc_q, pcsrc_d;
  logic [N-1:0] pcbranch_q, pcbranch_d;
  logic         misaligned_s;

  assign misaligned_s = |aluResult_E[ALIGN_BITS-1:0];

  // Next-state and capture logic; handshake outputs are decoded from the next state.
  always_comb begin
    state_d      = state_q;
    alu_d        = alu_q;
    wdata_d      = wdata_q;
    is_load_d    = is_load_q;
    is_store_d   = is_store_q;
    alu_w_d      = alu_w_q;
    rdata_w_d    = rdata_w_q;
    misalign_w_d = misalign_w_q;
    pcbranch_d   = pcbranch_q;
    pcsrc_d      = 1'b0;

    case (state_q)
      IDLE: begin
        if (valid_E) begin
          alu_d      = aluResult_E;
          wdata_d    = writeData_E;
          is_load_d  = memRead_E;
          is_store_d = memWrite_E & ~memRead_E;
          pcbranch_d = PCBranch_E;
          pcsrc_d    = branch_E & zero_E;
          if (!(memRead_E || memWrite_E)) begin
            state_d      = DONE;
            alu_w_d      = aluResult_E;
            rdata_w_d    = {N{1'b0}};
            misalign_w_d = 1'b0;
          end else if (misaligned_s) begin
            state_d      = DONE;
            alu_w_d      = aluResult_E;
            rdata_w_d    = {N{1'b0}};
            misalign_w_d = 1'b1;
          end else begin
            state_d = REQ;
          end
        end else begin
          state_d = IDLE;
        end
      end
      REQ: begin
        if (dm_gnt) begin
          if (!is_load_q) begin
            state_d      = DONE;
            alu_w_d      = alu_q;
            rdata_w_d    = {N{1'b0}};
            misalign_w_d = 1'b0;
          end else if (dm_rvalid) begin
            state_d      = DONE;
            alu_w_d      = alu_q;
            rdata_w_d    = dm_rdata;
            misalign_w_d = 1'b0;
          end else begin
            state_d = WAIT;
          end
        end else begin
          state_d = REQ;
        end
      end
      WAIT: begin
        if (dm_rvalid) begin
          state_d      = DONE;
          alu_w_d      = alu_q;
          rdata_w_d    = dm_rdata;
          misalign_w_d = 1'b0;
        end else begin
          state_d = WAIT;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    ready_d   = (state_d == IDLE);
    dm_req_d  = (state_d == REQ);
    dm_we_d   = (state_d == REQ) & is_store_d;
    valid_w_d = (state_d == DONE);
  end

  // State and output registers; async reset drops dm_req at once and returns to IDLE.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      alu_q        <= {N{1'b0}};
      wdata_q      <= {N{1'b0}};
      is_load_q    <= 1'b0;
      is_store_q   <= 1'b0;
      ready_q      <= 1'b1;
      dm_req_q     <= 1'b0;
      dm_we_q      <= 1'b0;
      valid_w_q    <= 1'b0;
      alu_w_q      <= {N{1'b0}};
      rdata_w_q    <= {N{1'b0}};
      misalign_w_q <= 1'b0;
      pcsrc_q      <= 1'b0;
      pcbranch_q   <= {N{1'b0}};
    end else begin
      state_q      <= state_d;
      alu_q        <= alu_d;
      wdata_q      <= wdata_d;
      is_load_q    <= is_load_d;
      is_store_q   <= is_store_d;
      ready_q      <= ready_d;
      dm_req_q     <= dm_req_d;
      dm_we_q      <= dm_we_d;
      valid_w_q    <= valid_w_d;
      alu_w_q      <= alu_w_d;
      rdata_w_q    <= rdata_w_d;
      misalign_w_q <= misalign_w_d;
      pcsrc_q      <= pcsrc_d;
      pcbranch_q   <= pcbranch_d;
    end
  end

  assign ready_E     = ready_q;
  assign dm_req      = dm_req_q;
  assign dm_we       = dm_we_q;
  assign dm_addr     = alu_q;
  assign dm_wdata    = wdata_q;
  assign valid_W     = valid_w_q;
  assign aluResult_W = alu_w_q;
  assign readData_W  = rdata_w_q;
  assign misalign_W  = misalign_w_q;
  assign PCSrc_M     = pcsrc_q;
  assign PCBranch_M  = pcbranch_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed self-checking bench for mem_access_unit with hand-computed expectations.
module tb_mem_access_unit;

  localparam int N = 64;

  logic         clk;
  logic         reset;
  logic         valid_E, memRead_E, memWrite_E, branch_E, zero_E;
  logic [N-1:0] aluResult_E, writeData_E, PCBranch_E;
  logic         ready_E, dm_req, dm_we;
  logic [N-1:0] dm_addr, dm_wdata, dm_rdata;
  logic         dm_gnt, dm_rvalid;
  logic         valid_W, misalign_W, PCSrc_M;
  logic [N-1:0] aluResult_W, readData_W, PCBranch_M;

  int checks = 0;
  int errors = 0;

  mem_access_unit #(.N(N)) dut (
    .clk(clk), .reset(reset),
    .valid_E(valid_E), .memRead_E(memRead_E), .memWrite_E(memWrite_E),
    .branch_E(branch_E), .aluResult_E(aluResult_E), .writeData_E(writeData_E),
    .PCBranch_E(PCBranch_E), .zero_E(zero_E), .ready_E(ready_E),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_gnt(dm_gnt), .dm_rvalid(dm_rvalid), .dm_rdata(dm_rdata),
    .valid_W(valid_W), .aluResult_W(aluResult_W), .readData_W(readData_W),
    .misalign_W(misalign_W), .PCSrc_M(PCSrc_M), .PCBranch_M(PCBranch_M)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [N-1:0] got, input logic [N-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    valid_E = 1'b0; memRead_E = 1'b0; memWrite_E = 1'b0; branch_E = 1'b0;
    zero_E = 1'b0; aluResult_E = '0; writeData_E = '0; PCBranch_E = '0;
  endtask

  task automatic issue(input logic rd, input logic wr, input logic br, input logic z,
                       input logic [N-1:0] alu, input logic [N-1:0] wd, input logic [N-1:0] pcb);
    valid_E = 1'b1; memRead_E = rd; memWrite_E = wr; branch_E = br; zero_E = z;
    aluResult_E = alu; writeData_E = wd; PCBranch_E = pcb;
  endtask

  initial begin
    reset = 1'b1;
    idle_inputs();
    dm_gnt = 1'b0; dm_rvalid = 1'b0; dm_rdata = '0;
    #12;
    check_eq("rst_ready", ready_E, 1);
    check_eq("rst_req", dm_req, 0);
    check_eq("rst_validW", valid_W, 0);
    check_eq("rst_pcsrc", PCSrc_M, 0);
    check_eq("rst_aluW", aluResult_W, 0);
    @(negedge clk);
    reset = 1'b0;
    tick();

    // Non-memory op
    issue(0, 0, 0, 0, 64'h10, 64'h0, 64'h0);
    tick();
    idle_inputs();
    check_eq("alu_validW", valid_W, 1);
    check_eq("alu_aluW", aluResult_W, 64'h10);
    check_eq("alu_rdataW", readData_W, 0);
    check_eq("alu_mis", misalign_W, 0);
    check_eq("alu_req", dm_req, 0);
    check_eq("alu_ready_done", ready_E, 0);
    tick();
    check_eq("alu_validW_pulse", valid_W, 0);
    check_eq("alu_ready_idle", ready_E, 1);
    check_eq("alu_aluW_hold", aluResult_W, 64'h10);

    // CBZ taken, then not taken
    issue(0, 0, 1, 1, 64'h0, 64'h0, 64'h400);
    tick();
    idle_inputs();
    check_eq("cbz_pcsrc", PCSrc_M, 1);
    check_eq("cbz_target", PCBranch_M, 64'h400);
    check_eq("cbz_validW", valid_W, 1);
    tick();
    check_eq("cbz_pcsrc_pulse", PCSrc_M, 0);
    check_eq("cbz_target_hold", PCBranch_M, 64'h400);
    issue(0, 0, 1, 0, 64'h5, 64'h0, 64'h800);
    tick();
    idle_inputs();
    check_eq("cbznt_pcsrc", PCSrc_M, 0);
    check_eq("cbznt_target", PCBranch_M, 64'h800);
    tick();

    // Load with two REQ cycles before grant, rvalid one cycle after
    issue(1, 0, 0, 0, 64'h20, 64'h0, 64'h0);
    tick();
    idle_inputs();
    for (int i = 0; i < 2; i++) begin
      check_eq("ld_req", dm_req, 1);
      check_eq("ld_addr", dm_addr, 64'h20);
      check_eq("ld_we", dm_we, 0);
      check_eq("ld_ready", ready_E, 0);
      tick();
    end
    check_eq("ld_req_g", dm_req, 1);
    check_eq("ld_addr_g", dm_addr, 64'h20);
    dm_gnt = 1'b1;
    tick();
    dm_gnt = 1'b0;
    check_eq("ld_wait_req", dm_req, 0);
    check_eq("ld_wait_ready", ready_E, 0);
    check_eq("ld_wait_validW", valid_W, 0);
    dm_rvalid = 1'b1; dm_rdata = 64'hDEADBEEF;
    tick();
    dm_rvalid = 1'b0; dm_rdata = '0;
    check_eq("ld_validW", valid_W, 1);
    check_eq("ld_rdataW", readData_W, 64'hDEADBEEF);
    check_eq("ld_aluW", aluResult_W, 64'h20);
    tick();
    check_eq("ld_validW_pulse", valid_W, 0);
    check_eq("ld_rdata_hold", readData_W, 64'hDEADBEEF);

    // Store with immediate grant and a stray rvalid
    issue(0, 1, 0, 0, 64'h8, 64'h55, 64'h0);
    dm_gnt = 1'b1; dm_rvalid = 1'b1; dm_rdata = 64'h99;
    tick();
    idle_inputs();
    check_eq("st_req", dm_req, 1);
    check_eq("st_we", dm_we, 1);
    check_eq("st_addr", dm_addr, 64'h8);
    check_eq("st_wdata", dm_wdata, 64'h55);
    check_eq("st_validW_early", valid_W, 0);
    tick();
    dm_gnt = 1'b0; dm_rvalid = 1'b0; dm_rdata = '0;
    check_eq("st_validW", valid_W, 1);
    check_eq("st_rdataW", readData_W, 0);
    check_eq("st_aluW", aluResult_W, 64'h8);
    check_eq("st_req_off", dm_req, 0);
    tick();

    // Read+write both set behaves as a load; same-cycle gnt and rvalid
    issue(1, 1, 0, 0, 64'h18, 64'h77, 64'h0);
    tick();
    idle_inputs();
    check_eq("rw_we", dm_we, 0);
    check_eq("rw_req", dm_req, 1);
    dm_gnt = 1'b1; dm_rvalid = 1'b1; dm_rdata = 64'h1234;
    tick();
    dm_gnt = 1'b0; dm_rvalid = 1'b0; dm_rdata = '0;
    check_eq("rw_validW", valid_W, 1);
    check_eq("rw_rdataW", readData_W, 64'h1234);
    tick();

    // Misaligned load
    issue(1, 0, 0, 0, 64'h13, 64'h0, 64'h0);
    tick();
    idle_inputs();
    check_eq("mis_validW", valid_W, 1);
    check_eq("mis_flag", misalign_W, 1);
    check_eq("mis_req", dm_req, 0);
    check_eq("mis_rdataW", readData_W, 0);
    check_eq("mis_aluW", aluResult_W, 64'h13);
    tick();
    check_eq("mis_flag_hold", misalign_W, 1);

    // Reset asserted while in REQ then WAIT
    issue(1, 0, 0, 0, 64'h40, 64'h0, 64'h0);
    tick();
    idle_inputs();
    check_eq("rw8_req", dm_req, 1);
    dm_gnt = 1'b1;
    tick();
    dm_gnt = 1'b0;
    check_eq("rwait_ready_pre", ready_E, 0);
    #2;
    reset = 1'b1;
    #1;
    check_eq("rwait_ready", ready_E, 1);
    check_eq("rwait_req", dm_req, 0);
    @(negedge clk);
    reset = 1'b0;
    dm_rvalid = 1'b1; dm_rdata = 64'hBAD;
    tick();
    dm_rvalid = 1'b0;
    check_eq("rwait_validW", valid_W, 0);
    check_eq("rwait_rdataW", readData_W, 0);
    check_eq("rwait_ready_post", ready_E, 1);

    // Reset mid-REQ drops dm_req without waiting for a clock
    issue(0, 1, 0, 0, 64'h30, 64'hAA, 64'h0);
    tick();
    idle_inputs();
    check_eq("rreq_req_pre", dm_req, 1);
    #2;
    reset = 1'b1;
    #1;
    check_eq("rreq_req", dm_req, 0);
    check_eq("rreq_we", dm_we, 0);
    @(negedge clk);
    reset = 1'b0;
    dm_gnt = 1'b1;
    tick();
    dm_gnt = 1'b0;
    check_eq("rreq_validW", valid_W, 0);
    check_eq("rreq_req_post", dm_req, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
